// File: rtl/pos_event_pkg.sv
// Shared definitions for the cursor position event FIFO.
// Holds the entry layout and the helpers that pack and unpack entries.
package pos_event_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int POS_W         = 16;
    localparam int ENTRY_W       = 32;
    localparam int X_LSB         = 0;
    localparam int Y_LSB         = 16;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic entry_t pack_entry(input logic [POS_W-1:0] x,
                                          input logic [POS_W-1:0] y);
        entry_t e;
        e = '0;
        e[X_LSB +: POS_W] = x;
        e[Y_LSB +: POS_W] = y;
        return e;
    endfunction

    function automatic logic [POS_W-1:0] unpack_x(input entry_t e);
        return e[X_LSB +: POS_W];
    endfunction

    function automatic logic [POS_W-1:0] unpack_y(input entry_t e);
        return e[Y_LSB +: POS_W];
    endfunction

endpackage

// File: rtl/pos_event_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset; validity is tracked by the FIFO.
module pos_event_ram
    import pos_event_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t mem [DEPTH];

    // Registered write of one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pos_event_fifo.sv
// Cursor position event FIFO with first-word-fall-through output.
// When full, a new position without a simultaneous pop replaces the newest
// entry instead of being dropped, so the consumer always sees the latest
// cursor position; the sticky overflow flag records that this happened.
module pos_event_fifo
    import pos_event_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [POS_W-1:0]   i_x_pos,
    input  logic [POS_W-1:0]   i_y_pos,
    input  logic               i_valid,
    output logic [ENTRY_W-1:0] o_rd_data,
    output logic               o_rd_valid,
    input  logic               i_rd_ready,
    output logic [CW-1:0]      o_count,
    output logic               o_overflow,
    input  logic               i_clr_overflow,
    input  logic               i_irq_en,
    output logic               o_irq
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          not_empty;
    logic          full;
    logic          pop;
    logic          push_adv;
    logic          ovf_set;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    entry_t        ram_rdata;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = not_empty & i_rd_ready;
    // A push advances the tail unless it must coalesce into the newest entry.
    assign push_adv  = i_valid & (~full | pop);

    // Next-state for pointers, occupancy, overflow and the RAM write port.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_set    = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = wr_ptr_q;

        if (i_valid) begin
            ram_we = 1'b1;
            if (push_adv) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                // Full with no pop: overwrite the most recently written slot.
                ram_waddr = wr_ptr_q - AW'(1);
                ovf_set   = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push_adv && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_adv) begin
            count_d = count_q - CW'(1);
        end

        // Set has priority over clear.
        overflow_d = ovf_set | (overflow_q & ~i_clr_overflow);
    end

    // State registers; storage itself is not reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    pos_event_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wdata (pack_entry(i_x_pos, i_y_pos)),
        .i_raddr (rd_ptr_q),
        .o_rdata (ram_rdata)
    );

    assign o_rd_data  = ram_rdata;
    assign o_rd_valid = not_empty;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_irq      = i_irq_en & not_empty;

endmodule

// File: tb/tb_pos_event_fifo.sv
// Scoreboard bench for pos_event_fifo: a queue-based reference model predicts
// status and popped entries; a negedge monitor compares against the DUT.
module tb_pos_event_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          i_clk;
    logic          i_reset_n;
    logic [15:0]   i_x_pos;
    logic [15:0]   i_y_pos;
    logic          i_valid;
    logic [31:0]   o_rd_data;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          i_clr_overflow;
    logic          i_irq_en;
    logic          o_irq;

    pos_event_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_x_pos        (i_x_pos),
        .i_y_pos        (i_y_pos),
        .i_valid        (i_valid),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow),
        .i_irq_en       (i_irq_en),
        .o_irq          (o_irq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cnt;
        bit          vld;
        bit          ovf;
        bit          irq;
        logic [31:0] head;
    } stat_t;

    stat_t       stat_q[$];
    logic [31:0] data_q[$];

    // Reference model: FIFO contents as a queue plus the sticky flag.
    logic [31:0] mq[$];
    bit          movf;
    bit          p_v, p_pop, p_clr;
    logic [31:0] p_entry;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    endtask

    // Apply the transaction presented during the previous cycle to the model.
    task automatic apply_pending();
        bit was_full;
        bit set;
        was_full = (mq.size() == DEPTH);
        set = 0;
        if (p_pop) void'(mq.pop_front());
        if (p_v) begin
            if (was_full && !p_pop) begin
                mq[mq.size()-1] = p_entry;
                set = 1;
            end else begin
                mq.push_back(p_entry);
            end
        end
        movf = set || (movf && !p_clr);
        p_v = 0; p_pop = 0; p_clr = 0;
    endtask

    task automatic step(input bit v, input logic [15:0] x, input logic [15:0] y,
                        input bit rdy, input bit clr, input bit ien);
        stat_t s;
        @(posedge i_clk);
        #1;
        apply_pending();
        i_valid        = v;
        i_x_pos        = x;
        i_y_pos        = y;
        i_rd_ready     = rdy;
        i_clr_overflow = clr;
        i_irq_en       = ien;
        s.cnt  = mq.size();
        s.vld  = (mq.size() != 0);
        s.ovf  = movf;
        s.irq  = ien && s.vld;
        s.head = s.vld ? mq[0] : 32'h0;
        stat_q.push_back(s);
        p_pop   = rdy && (mq.size() != 0);
        p_v     = v;
        p_entry = {y, x};
        p_clr   = clr;
        if (p_pop) data_q.push_back(mq[0]);
    endtask

    task automatic idle_look(input bit ien);
        step(0, 16'h0, 16'h0, 0, 0, ien);
        @(negedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n      = 1'b0;
        i_valid        = 0;
        i_rd_ready     = 0;
        i_clr_overflow = 0;
        mq.delete();
        movf = 0;
        p_v = 0; p_pop = 0; p_clr = 0;
        stat_q.delete();
        data_q.delete();
        repeat (2) @(negedge i_clk);
        #2 i_reset_n = 1'b1;
    endtask

    stat_t ms;
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (stat_q.size() != 0) begin
                ms = stat_q.pop_front();
                check("count", 32'(o_count), 32'(ms.cnt));
                check("rd_valid", 32'(o_rd_valid), 32'(ms.vld));
                check("overflow", 32'(o_overflow), 32'(ms.ovf));
                check("irq", 32'(o_irq), 32'(ms.irq));
                if (ms.vld) check("head", o_rd_data, ms.head);
            end
            if (o_rd_valid && i_rd_ready) begin
                if (data_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
                else check("pop_data", o_rd_data, data_q.pop_front());
            end
        end
    end

    initial begin
        i_x_pos = 0; i_y_pos = 0; i_irq_en = 1;
        i_valid = 0; i_rd_ready = 0; i_clr_overflow = 0;
        i_reset_n = 0;
        #2;
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_valid", 32'(o_rd_valid), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        do_reset();

        // Single push into empty FIFO.
        step(1, 16'h0140, 16'h00F0, 0, 0, 1);
        idle_look(1);
        check("first_data", o_rd_data, 32'h00F00140);
        check("first_count", 32'(o_count), 32'd1);
        check("first_irq", 32'(o_irq), 32'd1);
        step(0, 0, 0, 1, 0, 1);

        // Fill, coalesce into the newest entry, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 0, 0, 1);
        step(1, 16'h0005, 16'h0007, 0, 0, 0);
        idle_look(0);
        check("full_count", 32'(o_count), 32'd8);
        check("full_ovf", 32'(o_overflow), 32'd1);
        check("full_irq_dis", 32'(o_irq), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 1, 0, 1);
        idle_look(1);
        check("coalesced_entry", o_rd_data, 32'h00070005);
        step(0, 0, 0, 1, 0, 1);

        // Set-wins over clear, then clear alone.
        for (int i = 0; i < DEPTH; i++) step(1, 16'h0300 + 16'(i), 16'h0400 + 16'(i), 0, 0, 1);
        step(1, 16'h0009, 16'h0009, 0, 1, 1);
        idle_look(1);
        check("set_beats_clr", 32'(o_overflow), 32'd1);
        step(0, 0, 0, 0, 1, 1);
        idle_look(1);
        check("clr_alone", 32'(o_overflow), 32'd0);

        // Full FIFO, push and pop together.
        step(1, 16'h0AAA, 16'h0BBB, 1, 0, 1);
        idle_look(1);
        check("fullpp_count", 32'(o_count), 32'd8);
        check("fullpp_ovf", 32'(o_overflow), 32'd0);
        check("fullpp_head", o_rd_data, 32'h04010301);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 1);

        // Pointer wrap.
        for (int i = 0; i < 5; i++) step(1, 16'h0500 + 16'(i), 16'h0600, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 16'h0700 + 16'(i), 16'h0800, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 1);
        idle_look(1);
        check("wrap_count", 32'(o_count), 32'd0);
        check("wrap_valid", 32'(o_rd_valid), 32'd0);

        // Asynchronous reset with entries held.
        for (int i = 0; i < 3; i++) step(1, 16'h0900 + 16'(i), 16'h0A00, 0, 0, 1);
        idle_look(1);
        check("pre_rst_count", 32'(o_count), 32'd3);
        #2 i_reset_n = 1'b0;
        #1;
        check("async_rst_count", 32'(o_count), 32'd0);
        check("async_rst_valid", 32'(o_rd_valid), 32'd0);
        check("async_rst_irq", 32'(o_irq), 32'd0);
        do_reset();
        step(1, 16'h1234, 16'h5678, 0, 0, 1);
        idle_look(1);
        check("post_rst_data", o_rd_data, 32'h56781234);
        check("post_rst_count", 32'(o_count), 32'd1);

        // Randomized traffic in three pressure phases.
        for (int ph = 0; ph < 3; ph++) begin
            int rp;
            rp = (ph == 0) ? 80 : (ph == 1) ? 15 : 50;
            for (int i = 0; i < 700; i++) begin
                step($urandom_range(0, 99) < 60, 16'($urandom), 16'($urandom),
                     $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 8,
                     $urandom_range(0, 1) == 1);
            end
        end

        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 1);
        idle_look(1);
        check("drain_count", 32'(o_count), 32'd0);
        check("stat_q_empty", 32'(stat_q.size()), 32'd0);
        check("data_q_empty", 32'(data_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pos_event_fifo.md
POS_EVENT_FIFO -- requirements
Module: pos_event_fifo

Interface
REQ-001 Parameter DEPTH, default 8; number of entries, power of two, 2..64.
REQ-002 Parameter CW, default $clog2(DEPTH)+1; occupancy counter width.
REQ-003 i_clk  input  1  single clock domain; all logic is rising-edge.
REQ-004 i_reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 i_x_pos  input  16  cursor X position, sampled on i_valid.
REQ-006 i_y_pos  input  16  cursor Y position, sampled on i_valid.
REQ-007 i_valid  input  1  single-cycle position-update strobe from the cursor tracker's interrupt output.
REQ-008 o_rd_data  output  32  head entry {y[15:0], x[15:0]}; meaningful only while o_rd_valid=1.
REQ-009 o_rd_valid  output  1  FIFO non-empty; head entry present.
REQ-010 i_rd_ready  input  1  consumer pop request.
REQ-011 o_count  output  CW  current occupancy, 0..DEPTH.
REQ-012 o_overflow  output  1  sticky flag; at least one update was coalesced while full.
REQ-013 i_clr_overflow  input  1  clears o_overflow.
REQ-014 i_irq_en  input  1  interrupt enable.
REQ-015 o_irq  output  1  level interrupt to the processor.

Function
REQ-016 Pop SHALL occur on a rising edge where o_rd_valid=1 and i_rd_ready=1; i_rd_ready while empty SHALL be ignored.
REQ-017 Push SHALL occur on a rising edge where i_valid=1; the entry {i_y_pos, i_x_pos} is written at the tail.
REQ-018 Not full, push only: write entry, advance write pointer, o_count+1.
REQ-019 Pop only: advance read pointer, o_count-1.
REQ-020 Push and pop in the same cycle, including the full case: both SHALL complete and o_count SHALL stay unchanged; o_overflow SHALL not be set.
REQ-021 Full (o_count=DEPTH), push without pop: the newest entry (tail-1) SHALL be overwritten with the new position; pointers and o_count unchanged; o_overflow set to 1 on the next edge.
REQ-022 Push into empty FIFO: o_rd_valid=1 and o_rd_data=new entry one cycle after the push edge; there is no same-cycle bypass.
REQ-023 Output SHALL be first-word-fall-through: o_rd_data SHALL always show the head entry, and after a pop SHALL show the next entry in the following cycle.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be derived from o_count only.
REQ-025 o_overflow: i_clr_overflow=1 clears it; set and clear in the same cycle SHALL leave it set (set wins).
REQ-026 o_irq SHALL equal i_irq_en AND (o_count != 0), decoded from registered state with no input-to-output combinational path other than i_irq_en.
REQ-027 o_rd_valid SHALL equal (o_count != 0).
REQ-028 Entry order SHALL be preserved; entries are never dropped except by the coalescing in REQ-021.

Reset
REQ-029 i_reset_n=0 SHALL immediately force o_count=0, both pointers=0, o_rd_valid=0, o_overflow=0, o_irq=0.
REQ-030 Storage contents are not reset; o_rd_data SHALL be don't-care while o_rd_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL behave as a push into an empty FIFO.
REQ-032 Deassertion SHALL be synchronised externally; the block SHALL accept no push or pop on the edge coincident with deassertion.

Structure
REQ-033 A shared package pos_event_pkg SHALL hold: DEPTH default, entry width (32), the X/Y field offsets, and the entry packing/unpacking functions.
REQ-034 Storage SHALL be a sub-module pos_event_ram: DEPTH x 32, one synchronous write port, one asynchronous read port, with no reset.
REQ-035 The pointer, count, overflow and irq logic SHALL reside in pos_event_fifo.

Verification
REQ-036 Reset, then push (x=0x0140, y=0x00F0) -> next cycle: o_rd_valid=1, o_rd_data=0x00F00140, o_count=1; with i_irq_en=1, o_irq=1.
REQ-037 Push 8 distinct entries with no pops, then push x=0x0005, y=0x0007 -> o_count=8, o_overflow=1, 8th entry reads 0x00070005, entries 1-7 unchanged, popped in order.
REQ-038 Full FIFO, push and pop in the same cycle -> o_count stays 8, o_overflow stays 0, head advances, new entry is at tail.
REQ-039 Fill 5 entries, pop 5, push 6 (pointer wrap) -> pops return the 6 new entries in order; o_count ends at 0; o_rd_valid=0.
REQ-040 o_overflow=1, assert i_clr_overflow in a cycle with another full-FIFO push -> o_overflow stays 1; clear alone next cycle -> 0.
REQ-041 Assert i_reset_n=0 asynchronously between edges with 3 entries held -> o_count=0, o_rd_valid=0, o_irq=0 before the next edge.
